// File: rtl/warp_dispatcher_pkg.sv
// Shared types for the kernel-launch dispatcher: per-core kernel descriptor and FSM states.
package warp_dispatcher_pkg;

    localparam int unsigned WarpIdW = 4;
    localparam logic [WarpIdW-1:0] NoWarpId = 4'b1111;

    typedef struct packed {
        logic [31:0]        start_pc;
        logic [WarpIdW-1:0] warp_id;
    } kernel_t;

    localparam kernel_t KernelIdle = '{start_pc: 32'h0, warp_id: NoWarpId};

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StDone
    } disp_state_e;

endpackage

// File: rtl/core_select_enc.sv
// Lowest-index-first priority encoder over the per-core eligible vector.
module core_select_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    eligible,
    output logic            found,
    output logic [IdxW-1:0] index
);

    // Scan downwards so the lowest set bit is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                index = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/warp_dispatcher.sv
// Kernel-launch front end: issues one warp per cycle to the lowest free core, counts
// completions and pulses kernel_done once every warp of the launch has retired.
module warp_dispatcher
    import warp_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned WARP_W    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                launch_valid,
    output logic                                launch_ready,
    input  logic [31:0]                         launch_pc,
    input  logic [WARP_W-1:0]                   launch_warps,
    output kernel_t [NUM_CORES-1:0]             core_kernel_out,
    output logic [NUM_CORES-1:0]                core_start,
    input  logic [NUM_CORES-1:0]                core_finished,
    input  logic [NUM_CORES-1:0][WARP_W-1:0]    core_finished_warp_id,
    output logic                                kernel_done,
    output logic                                busy,
    output logic [WARP_W-1:0]                   warps_outstanding,
    output logic                                err_bad_id
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    disp_state_e              state_q, state_d;
    logic [31:0]              pc_q, pc_d;
    logic [WARP_W-1:0]        count_q, count_d;
    logic [WARP_W-1:0]        next_id_q, next_id_d;
    logic [WARP_W-1:0]        retired_q, retired_d;
    logic [NUM_CORES-1:0]     core_busy_q, core_busy_d;
    kernel_t [NUM_CORES-1:0]  kernel_q, kernel_d;
    logic                     err_bad_id_q, err_bad_id_d;

    logic [NUM_CORES-1:0]     eligible;
    logic                     sel_found;
    logic [IdxW-1:0]          sel_idx;

    // A core still holding finished from its last warp must drop it before reuse.
    assign eligible = ~core_busy_q & ~core_finished;

    core_select_enc #(
        .N    (NUM_CORES),
        .IdxW (IdxW)
    ) u_core_select_enc (
        .eligible (eligible),
        .found    (sel_found),
        .index    (sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        next_id_d    = next_id_q;
        retired_d    = retired_q;
        core_busy_d  = core_busy_q;
        kernel_d     = kernel_q;
        err_bad_id_d = err_bad_id_q;
        core_start   = '0;

        for (int c = 0; c < NUM_CORES; c++) begin
            if (core_finished[c] && core_busy_q[c]) begin
                core_busy_d[c] = 1'b0;
                retired_d      = retired_d + WARP_W'(1);
                if (core_finished_warp_id[c] != kernel_q[c].warp_id) begin
                    err_bad_id_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (launch_valid && (launch_warps != '0)) begin
                    pc_d      = launch_pc;
                    count_d   = launch_warps;
                    next_id_d = '0;
                    retired_d = '0;
                    state_d   = StDispatch;
                end
            end
            StDispatch: begin
                if ((next_id_q < count_q) && sel_found) begin
                    core_start[sel_idx]  = 1'b1;
                    core_busy_d[sel_idx] = 1'b1;
                    kernel_d[sel_idx]    = '{start_pc: pc_q, warp_id: next_id_q};
                    next_id_d            = next_id_q + WARP_W'(1);
                end
                if (next_id_d == count_q) begin
                    state_d = (retired_d == count_q) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (retired_d == count_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            count_q      <= '0;
            next_id_q    <= '0;
            retired_q    <= '0;
            core_busy_q  <= '0;
            kernel_q     <= {NUM_CORES{KernelIdle}};
            err_bad_id_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            next_id_q    <= next_id_d;
            retired_q    <= retired_d;
            core_busy_q  <= core_busy_d;
            kernel_q     <= kernel_d;
            err_bad_id_q <= err_bad_id_d;
        end
    end

    // The new descriptor is visible in the same cycle as its start pulse.
    assign core_kernel_out   = kernel_d;
    assign launch_ready      = (state_q == StIdle);
    assign busy              = (state_q != StIdle);
    assign kernel_done       = (state_q == StDone);
    assign warps_outstanding = next_id_q - retired_q;
    assign err_bad_id        = err_bad_id_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// Self-checking bench for warp_dispatcher: behavioural core models plus start/done scoreboards.
module tb_warp_dispatcher;
    import warp_dispatcher_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned WW = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   launch_valid;
    logic                   launch_ready;
    logic [31:0]            launch_pc;
    logic [WW-1:0]          launch_warps;
    kernel_t [NC-1:0]       core_kernel_out;
    logic [NC-1:0]          core_start;
    logic [NC-1:0]          core_finished;
    logic [NC-1:0][WW-1:0]  core_finished_warp_id;
    logic                   kernel_done;
    logic                   busy;
    logic [WW-1:0]          warps_outstanding;
    logic                   err_bad_id;

    always #5 clk = ~clk;

    warp_dispatcher #(
        .NUM_CORES (NC),
        .WARP_W    (WW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .launch_valid          (launch_valid),
        .launch_ready          (launch_ready),
        .launch_pc             (launch_pc),
        .launch_warps          (launch_warps),
        .core_kernel_out       (core_kernel_out),
        .core_start            (core_start),
        .core_finished         (core_finished),
        .core_finished_warp_id (core_finished_warp_id),
        .kernel_done           (kernel_done),
        .busy                  (busy),
        .warps_outstanding     (warps_outstanding),
        .err_bad_id            (err_bad_id)
    );

    typedef struct {
        int          core;
        int          cyc;
        logic [31:0] pc;
        logic [3:0]  id;
    } start_exp_t;

    start_exp_t start_q[$];
    int         done_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         cfg_delay [NC];
    int         cfg_hold  [NC];
    bit         cfg_use_bad [NC];
    logic [3:0] cfg_bad [NC];

    int         m_wait [NC];
    int         m_hold [NC];
    bit         m_busy [NC];
    logic [3:0] m_id   [NC];
    int         m_count, m_issued, m_retired;
    int         max_wo, dbl_cyc, done_cnt;
    int         core_of [16];
    int         start_cyc [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset();
        check("rst_ready", launch_ready, 1);
        check("rst_start", core_start, 0);
        check("rst_done", kernel_done, 0);
        check("rst_busy", busy, 0);
        check("rst_wo", warps_outstanding, 0);
        check("rst_err", err_bad_id, 0);
        for (int c = 0; c < NC; c++) begin
            check("rst_kout", core_kernel_out[c], {32'h0, 4'hF});
        end
    endtask

    task automatic model_flush();
        start_q.delete();
        done_q.delete();
        for (int c = 0; c < NC; c++) begin
            m_wait[c] = 0;
            m_hold[c] = 0;
            m_busy[c] = 0;
        end
        core_finished = '0;
        m_count   = 0;
        m_issued  = 0;
        m_retired = 0;
    endtask

    task automatic set_cores(input int d0, input int d1, input int d2, input int d3, input int h1);
        cfg_delay[0] = d0; cfg_delay[1] = d1; cfg_delay[2] = d2; cfg_delay[3] = d3;
        for (int c = 0; c < NC; c++) begin
            cfg_hold[c]    = 1;
            cfg_use_bad[c] = 0;
        end
        cfg_hold[1] = h1;
        max_wo  = 0;
        dbl_cyc = -1;
    endtask

    // One clock: drive core-model inputs just after the edge, sample settled outputs later.
    task automatic step();
        start_exp_t e;
        int n_ret;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (core_finished[c]) begin
                m_hold[c]--;
                if (m_hold[c] <= 0) core_finished[c] = 1'b0;
            end else if (m_wait[c] > 0) begin
                m_wait[c]--;
                if (m_wait[c] == 0) begin
                    core_finished[c]         = 1'b1;
                    m_hold[c]                = cfg_hold[c];
                    core_finished_warp_id[c] = cfg_use_bad[c] ? cfg_bad[c] : m_id[c];
                end
            end
        end
        #2;
        check("wo", warps_outstanding, m_issued - m_retired);
        if (m_issued - m_retired > max_wo) max_wo = m_issued - m_retired;
        n_ret = 0;
        for (int c = 0; c < NC; c++) begin
            if (core_finished[c] && m_busy[c]) begin
                m_busy[c] = 0;
                m_retired++;
                n_ret++;
                if (m_retired == m_count && m_issued == m_count) done_q.push_back(cyc + 1);
            end
        end
        if (n_ret >= 2) dbl_cyc = cyc;
        if (core_start != '0) check("start_onehot", $onehot(core_start), 1);
        for (int c = 0; c < NC; c++) begin
            if (core_start[c]) begin
                check("start_elig", {m_busy[c], core_finished[c]}, 2'b00);
                if (start_q.size() == 0) begin
                    check("start_unexp", 1, 0);
                end else begin
                    e = start_q.pop_front();
                    check("start_pc", core_kernel_out[c].start_pc, e.pc);
                    check("start_id", core_kernel_out[c].warp_id, e.id);
                    if (e.core >= 0) check("start_core", c, e.core);
                    if (e.cyc >= 0) check("start_cyc", cyc, e.cyc);
                    core_of[e.id]   = c;
                    start_cyc[e.id] = cyc;
                    m_id[c]         = e.id;
                end
                m_busy[c] = 1;
                m_wait[c] = cfg_delay[c];
                m_issued++;
            end
        end
        if (done_q.size() != 0 && done_q[0] < cyc) begin
            check("done_missing", 0, 1);
            void'(done_q.pop_front());
        end
        if (kernel_done) begin
            done_cnt++;
            check("ready_in_done", launch_ready, 0);
            if (done_q.size() == 0) check("done_unexp", 1, 0);
            else check("done_cyc", cyc, done_q.pop_front());
        end
    endtask

    task automatic launch(input logic [31:0] pc, input int n, input bit exact);
        start_exp_t e;
        check("launch_ready", launch_ready, 1);
        launch_pc    = pc;
        launch_warps = WW'(n);
        launch_valid = 1'b1;
        if (n != 0) begin
            m_count   = n;
            m_issued  = 0;
            m_retired = 0;
            for (int i = 0; i < n; i++) begin
                e.core = exact ? i : -1;
                e.cyc  = exact ? cyc + 1 + i : -1;
                e.pc   = pc;
                e.id   = 4'(i);
                start_q.push_back(e);
            end
        end
        step();
        launch_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        step();
        check("idle_ready", launch_ready, 1);
        check("idle_busy", busy, 0);
        check("sb_starts", start_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                   = 1'b1;
        launch_valid          = 1'b0;
        launch_pc             = '0;
        launch_warps          = '0;
        core_finished         = '0;
        core_finished_warp_id = '0;
        done_cnt              = 0;
        model_flush();
        set_cores(5, 5, 5, 5, 1);
        #12;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset in the middle of dispatch abandons the launch.
        set_cores(50, 50, 50, 50, 1);
        launch(32'h200, 6, 0);
        step();
        step();
        rst = 1'b1;
        #1;
        check_reset();
        model_flush();
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t1_no_done", done_cnt, 0);

        // Basic three-warp kernel with exact core/cycle placement.
        set_cores(5, 5, 5, 5, 1);
        launch(32'h100, 3, 1);
        wait_done(60);
        check("t2_err", err_bad_id, 0);

        // Core 1 finishes early and holds finished for three cycles.
        set_cores(10, 2, 10, 10, 3);
        launch(32'h400, 6, 0);
        wait_done(120);
        check("t3_w4_core", core_of[4], 1);
        check("t3_max_wo", max_wo <= 4, 1);

        // Cores 0 and 2 retire in the same cycle; both reusable immediately.
        set_cores(6, 30, 4, 30, 1);
        launch(32'h500, 6, 0);
        wait_done(150);
        check("t4_dbl_seen", dbl_cyc >= 0, 1);
        check("t4_w4_core", core_of[4], 0);
        check("t4_w4_cyc", start_cyc[4], dbl_cyc + 1);
        check("t4_w5_core", core_of[5], 2);
        check("t4_w5_cyc", start_cyc[5], dbl_cyc + 2);

        // Wrong completion id sets the sticky error but the kernel still completes.
        set_cores(3, 3, 3, 3, 1);
        cfg_use_bad[0] = 1;
        cfg_bad[0]     = 4'b0111;
        check("t5_err_before", err_bad_id, 0);
        launch(32'h600, 2, 0);
        wait_done(60);
        check("t5_err_after", err_bad_id, 1);

        // Zero-warp launch is ignored; launches while busy are ignored.
        set_cores(8, 8, 8, 8, 1);
        launch(32'h700, 0, 0);
        for (int i = 0; i < 4; i++) step();
        check("t6_zero_ready", launch_ready, 1);
        check("t6_zero_busy", busy, 0);
        check("t6_err_sticky", err_bad_id, 1);
        launch(32'h300, 2, 0);
        launch_pc    = 32'hDEAD;
        launch_warps = 4'd5;
        launch_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        launch_valid = 1'b0;
        wait_done(60);
        for (int i = 0; i < 4; i++) step();
        check("t6_busy_after", busy, 0);
        check("sb_done", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
